// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3) with leading-zero blank mask and saturation.
// Latency: o_valid is high in the cycle after edge BIN_WIDTH+1, counting the start-accept edge as edge 0.
// Backpressure: none; i_start is only accepted in IDLE and ignored while o_busy is high.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH  = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [BIN_WIDTH-1:0]    i_bin,
  output logic                    o_busy,
  output logic                    o_valid,
  output logic [4*NUM_DIGITS-1:0] o_bcd,
  output logic [NUM_DIGITS-1:0]   o_blank,
  output logic                    o_overflow
);

  localparam int ACC_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  // Largest value representable in NUM_DIGITS decimal digits; larger inputs saturate to it.
  localparam logic [BIN_WIDTH-1:0] MAX_VAL = BIN_WIDTH'(10 ** NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(BIN_WIDTH - 1);

  // With everything zero, every digit except the units digit is a leading zero.
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = {{(NUM_DIGITS - 1){1'b1}}, 1'b0};

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]                 state;
  logic [CNT_W-1:0]           cnt;
  logic [BIN_WIDTH-1:0]       bin_reg;
  logic [ACC_W-1:0]           acc;
  logic                       ovf_flag;

  logic [ACC_W-1:0]           acc_adj;
  logic [ACC_W+BIN_WIDTH-1:0] shifted;
  logic [NUM_DIGITS-1:0]      blank_next;
  logic                       all_zero;

  assign o_busy = (state != IDLE);

  // Add-3 correction on every accumulator nibble that is 5 or more, ahead of the shift.
  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // One conversion step: the corrected accumulator and the remaining binary bits move left as one word.
  always_comb begin
    shifted = {acc_adj, bin_reg} << 1;
  end

  // Leading-zero mask: walk down from the top digit while all digits seen so far are zero; units never blank.
  always_comb begin
    blank_next = '0;
    all_zero   = 1'b1;
    for (int n = NUM_DIGITS - 1; n >= 1; n--) begin
      all_zero      = all_zero & (acc[4*n +: 4] == 4'd0);
      blank_next[n] = all_zero;
    end
  end

  // Control FSM, datapath registers and output registers; outputs only update at completion.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bin_reg    <= '0;
      acc        <= '0;
      ovf_flag   <= 1'b0;
      o_valid    <= 1'b0;
      o_bcd      <= '0;
      o_blank    <= BLANK_RST;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            acc   <= '0;
            cnt   <= '0;
            state <= CONVERT;
            if (i_bin > MAX_VAL) begin
              bin_reg  <= MAX_VAL;
              ovf_flag <= 1'b1;
            end else begin
              bin_reg  <= i_bin;
              ovf_flag <= 1'b0;
            end
          end
        end
        CONVERT: begin
          acc     <= shifted[ACC_W+BIN_WIDTH-1:BIN_WIDTH];
          bin_reg <= shifted[BIN_WIDTH-1:0];
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state <= DONE;
          end
        end
        DONE: begin
          o_bcd      <= acc;
          o_blank    <= blank_next;
          o_overflow <= ovf_flag;
          o_valid    <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: vector table plus hand-written multi-cycle sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
// Edge numbers are counted from the start-accept edge (edge 0).
module tb_bin_to_bcd_seq;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [19:0] i_bin;
  logic        o_busy;
  logic        o_valid;
  logic [23:0] o_bcd;
  logic [5:0]  o_blank;
  logic        o_overflow;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [19:0] bin;
    logic [23:0] bcd;
    logic [5:0]  blank;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  bin_to_bcd_seq #(.BIN_WIDTH(20), .NUM_DIGITS(6)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_bin      (i_bin),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_bcd      (o_bcd),
    .o_blank    (o_blank),
    .o_overflow (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Start one conversion from idle and watch edges 1..30 for the completion strobe.
  task automatic run_conv(input string tag, input logic [19:0] bin, input logic [23:0] exp_bcd,
                          input logic [5:0] exp_blank, input logic exp_ovf);
    int          vedge;
    int          nvld;
    logic [23:0] cap_bcd;
    logic [5:0]  cap_blank;
    logic        cap_ovf;
    vedge     = -1;
    nvld      = 0;
    cap_bcd   = '0;
    cap_blank = '0;
    cap_ovf   = 1'b0;
    i_start = 1'b1;
    i_bin   = bin;
    step();
    i_start = 1'b0;
    i_bin   = ~bin;
    chk({tag, " busy after accept"}, 32'(o_busy), 32'd1);
    for (int k = 1; k <= 30; k++) begin
      step();
      if (o_valid) begin
        nvld++;
        if (vedge < 0) begin
          vedge     = k;
          cap_bcd   = o_bcd;
          cap_blank = o_blank;
          cap_ovf   = o_overflow;
        end
      end
    end
    chk({tag, " valid edge"}, 32'(vedge), 32'd21);
    chk({tag, " valid count"}, 32'(nvld), 32'd1);
    chk({tag, " bcd"}, 32'(cap_bcd), 32'(exp_bcd));
    chk({tag, " blank"}, 32'(cap_blank), 32'(exp_blank));
    chk({tag, " overflow"}, 32'(cap_ovf), 32'(exp_ovf));
    chk({tag, " bcd held"}, 32'(o_bcd), 32'(exp_bcd));
    chk({tag, " busy idle"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int          vedge;
    int          nvld;
    int          vedges [3];
    logic [23:0] vbcd [3];
    logic [23:0] cap_bcd;

    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{bin: 20'd0,       bcd: 24'h000000, blank: 6'b111110, ovf: 1'b0};
    vecs[1] = '{bin: 20'd123456,  bcd: 24'h123456, blank: 6'b000000, ovf: 1'b0};
    vecs[2] = '{bin: 20'd907,     bcd: 24'h000907, blank: 6'b111000, ovf: 1'b0};
    vecs[3] = '{bin: 20'd999999,  bcd: 24'h999999, blank: 6'b000000, ovf: 1'b0};
    vecs[4] = '{bin: 20'd1000000, bcd: 24'h999999, blank: 6'b000000, ovf: 1'b1};
    vecs[5] = '{bin: 20'd1048575, bcd: 24'h999999, blank: 6'b000000, ovf: 1'b1};
    vecs[6] = '{bin: 20'd10,      bcd: 24'h000010, blank: 6'b111100, ovf: 1'b0};
    vecs[7] = '{bin: 20'd5,       bcd: 24'h000005, blank: 6'b111110, ovf: 1'b0};

    // Reset with start asserted: reset must win and leave the block idle.
    i_rst   = 1'b1;
    i_start = 1'b1;
    i_bin   = 20'd77;
    @(negedge i_clk);
    step();
    step();
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset bcd", 32'(o_bcd), 32'd0);
    chk("reset blank", 32'(o_blank), 32'b111110);
    chk("reset overflow", 32'(o_overflow), 32'd0);
    i_rst   = 1'b0;
    i_start = 1'b0;
    step();
    chk("idle after reset busy", 32'(o_busy), 32'd0);

    for (int v = 0; v < 7; v++) begin
      run_conv($sformatf("vec%0d", v), vecs[v].bin, vecs[v].bcd, vecs[v].blank, vecs[v].ovf);
    end

    // Start pulse and input change mid-conversion must be ignored.
    i_start = 1'b1;
    i_bin   = 20'd42;
    step();
    i_start = 1'b0;
    vedge   = -1;
    nvld    = 0;
    cap_bcd = '0;
    for (int k = 1; k <= 50; k++) begin
      if (k == 5) begin
        i_start = 1'b1;
        i_bin   = 20'd77;
      end
      step();
      if (k == 5) i_start = 1'b0;
      if (o_valid) begin
        nvld++;
        if (vedge < 0) begin
          vedge   = k;
          cap_bcd = o_bcd;
        end
      end
    end
    chk("ignore start valid edge", 32'(vedge), 32'd21);
    chk("ignore start valid count", 32'(nvld), 32'd1);
    chk("ignore start bcd", 32'(cap_bcd), 32'h000042);
    chk("ignore start bcd held", 32'(o_bcd), 32'h000042);

    // Reset at edge 10 aborts the conversion without a strobe.
    i_start = 1'b1;
    i_bin   = 20'd999;
    step();
    i_start = 1'b0;
    nvld    = 0;
    for (int k = 1; k <= 30; k++) begin
      i_rst = (k == 10);
      step();
      if (o_valid) nvld++;
      if (k == 10) begin
        chk("abort busy", 32'(o_busy), 32'd0);
        chk("abort bcd", 32'(o_bcd), 32'd0);
        chk("abort blank", 32'(o_blank), 32'b111110);
        chk("abort overflow", 32'(o_overflow), 32'd0);
      end
    end
    i_rst = 1'b0;
    chk("abort valid count", 32'(nvld), 32'd0);
    run_conv("after abort", vecs[7].bin, vecs[7].bcd, vecs[7].blank, vecs[7].ovf);

    // Start held high: back-to-back conversions 22 cycles apart, each sampling i_bin at its accept edge.
    i_start = 1'b1;
    i_bin   = 20'd1;
    step();
    nvld = 0;
    for (int j = 0; j < 3; j++) begin
      vedges[j] = -1;
      vbcd[j]   = '0;
    end
    for (int k = 1; k <= 80; k++) begin
      if (k == 1)  i_bin = 20'd2;
      if (k == 23) i_bin = 20'd3;
      if (k == 45) i_start = 1'b0;
      step();
      if (o_valid) begin
        if (nvld < 3) begin
          vedges[nvld] = k;
          vbcd[nvld]   = o_bcd;
        end
        nvld++;
      end
    end
    chk("b2b valid count", 32'(nvld), 32'd3);
    chk("b2b edge 0", 32'(vedges[0]), 32'd21);
    chk("b2b edge 1", 32'(vedges[1]), 32'd43);
    chk("b2b edge 2", 32'(vedges[2]), 32'd65);
    chk("b2b bcd 0", 32'(vbcd[0]), 32'h000001);
    chk("b2b bcd 1", 32'(vbcd[1]), 32'h000002);
    chk("b2b bcd 2", 32'(vbcd[2]), 32'h000003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter BIN_WIDTH, default 20, giving the binary input width.
REQ-002 The block SHALL have parameter NUM_DIGITS, default 6, giving the BCD output digit count; 10^NUM_DIGITS-1 SHALL be less than 2^BIN_WIDTH.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; all ports are listed below, clock and reset first.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 The block SHALL have port i_rst, input, 1 bit: synchronous reset, active-high.
REQ-006 The block SHALL have port i_start, input, 1 bit: request a conversion of i_bin.
REQ-007 The block SHALL have port i_bin, input, BIN_WIDTH bits: unsigned binary value.
REQ-008 The block SHALL have port o_busy, output, 1 bit: conversion in progress.
REQ-009 The block SHALL have port o_valid, output, 1 bit: one-cycle completion strobe.
REQ-010 The block SHALL have port o_bcd, output, 4*NUM_DIGITS bits: packed BCD with digit 0 (units) at [3:0]; each nibble drives one downstream hex-to-7-segment decoder.
REQ-011 The block SHALL have port o_blank, output, NUM_DIGITS bits: leading-zero blank mask, where bit n=1 means digit n is a leading zero.
REQ-012 The block SHALL have port o_overflow, output, 1 bit: the last input exceeded 10^NUM_DIGITS-1.

Function
REQ-013 The FSM SHALL have states IDLE, CONVERT and DONE; o_busy SHALL be 1 whenever the state is not IDLE.
REQ-014 In IDLE with i_start=1, the block SHALL, at that edge, capture i_bin, clear the BCD accumulator and the shift counter, and go to CONVERT; i_start SHALL be ignored in all other states.
REQ-015 At capture, if i_bin > 10^NUM_DIGITS-1, the block SHALL substitute 10^NUM_DIGITS-1 (999999 at defaults) and set an internal overflow flag; otherwise it SHALL clear that flag.
REQ-016 In CONVERT, each cycle SHALL apply shift-and-add-3: add 3 to every accumulator nibble >= 5, then shift {accumulator, binary} left by 1, MSB first.
REQ-017 After exactly BIN_WIDTH CONVERT cycles, the block SHALL go to DONE.
REQ-018 In DONE, the block SHALL load o_bcd, o_blank and o_overflow from the accumulator and flag, pulse o_valid for exactly one cycle, and return to IDLE on the next edge.
REQ-019 With the start-accepting edge counted as edge 0, o_valid SHALL be high during the cycle following edge BIN_WIDTH+1 (edge 21 at defaults); a new start SHALL be accepted no earlier than edge BIN_WIDTH+2.
REQ-020 o_bcd, o_blank and o_overflow SHALL hold their values between completions and SHALL never show intermediate accumulator values.
REQ-021 o_blank bit n (n >= 1) SHALL be 1 iff digit n and all digits above it are 0; bit 0 SHALL always be 0.
REQ-022 An i_start held high continuously SHALL produce back-to-back conversions, one every BIN_WIDTH+2 cycles, each re-sampling i_bin at its accept edge.
REQ-023 Changes to i_bin after the accept edge SHALL NOT affect the conversion in progress.

Reset
REQ-024 When i_rst=1 at an edge, the block SHALL enter IDLE and set o_busy=0, o_valid=0, o_bcd=0, o_overflow=0, with o_blank set to all ones except bit 0; the counter and accumulator SHALL clear.
REQ-025 Reset SHALL take priority over i_start in the same cycle.
REQ-026 Reset during CONVERT or DONE SHALL abort the conversion with no o_valid pulse.

Verification
REQ-027 The bench SHALL cover: i_bin=0, start -> o_bcd=0x000000, o_blank=6'b111110, o_overflow=0, o_valid exactly at edge 21.
REQ-028 The bench SHALL cover: i_bin=123456 -> o_bcd=0x123456, o_blank=0; i_bin=907 -> o_bcd=0x000907, o_blank=6'b111000.
REQ-029 The bench SHALL cover: i_bin=999999 -> o_bcd=0x999999, o_overflow=0; i_bin=1000000 and i_bin=1048575 -> o_bcd=0x999999, o_overflow=1.
REQ-030 The bench SHALL cover: start accepted with i_bin=42, then i_start pulsed and i_bin changed to 77 at edge 5 -> single o_valid with o_bcd=0x000042, and no second conversion.
REQ-031 The bench SHALL cover: i_rst asserted at edge 10 of a conversion -> no o_valid, outputs at reset values, and a following start with i_bin=5 yields o_bcd=0x000005 at its edge 21.
REQ-032 The bench SHALL cover: i_start held high with i_bin=1, 2, 3 changing per accept -> o_valid pulses 22 cycles apart, showing 0x000001, 0x000002 and 0x000003 in turn.
